dso_wave_render: RTL and testbench
==================================

// Module: dso_wave_render
// PURPOSE
//  Pixel-stage renderer for the DSO HDMI path. Consumes vs/hs/de/act_x/act_y from the
//  video timing generator and replaces the test-pattern stage: draws graticule + one
//  8-bit sample trace. Samples live in an internal double-buffered line RAM filled by the
//  acquisition side; buffer swap is frame-synchronous (at vsync) to avoid tearing.
// PARAMETERS
//  X_BITS      12    width of act_x
//  Y_BITS      12    width of act_y
//  H_ACT       1920  active pixels per line
//  V_ACT       1080  active lines per frame
//  COLOR_DEPTH 8     bits per colour channel
//  ADDR_BITS   11    sample RAM address width (2048 samples per bank, >= H_ACT)
//  GRID_X      192   pixels per horizontal division (10 divisions)
//  GRID_Y      135   lines per vertical division (8 divisions)
//  WAVE_TOP    284   screen row of sample value 255; trace row = WAVE_TOP + 2*(255-s)
// PORTS
//  pix_clk    in   1   pixel clock, sole clock
//  rst        in   1   synchronous reset, active-high
//  vs_in      in   1   vsync from timing generator
//  hs_in      in   1   hsync from timing generator
//  de_in      in   1   active-video enable
//  act_x      in   X_BITS  active column (valid when de_in)
//  act_y      in   Y_BITS  active row (valid when de_in)
//  wr_en      in   1   sample write strobe (back bank)
//  wr_addr    in   ADDR_BITS  sample index = screen column
//  wr_data    in   8   sample value, 0 = bottom, 255 = top
//  wr_done    in   1   1-cycle pulse: back bank complete, request swap
//  wr_ready   out  1   back bank writable
//  swap_ack   out  1   1-cycle pulse when banks swap
//  vs_out     out  1   vs_in delayed 2 cycles
//  hs_out     out  1   hs_in delayed 2 cycles
//  de_out     out  1   de_in delayed 2 cycles
//  r_out/g_out/b_out  out  COLOR_DEPTH each  pixel colour
// BEHAVIOUR
//  - Reset: all outputs 0 except wr_ready=1; front bank=0; pending=0; counters=0.
//  - Latency 2: S1 registers RAM read at act_x (front bank) + grid flags; S2 computes colour.
//    vs/hs/de delayed identically; rgb = 0 whenever de_out=0.
//  - Grid: column counter gx (0..GRID_X-1) advances on de_in, clears at de_in rising edge;
//    row counter gy (0..GRID_Y-1) advances on de_in falling edge, clears on vs_in rising.
//    Grid pixel when gx==0, gy==0, act_x==H_ACT-1 or act_y==V_ACT-1 -> 0x40 grey.
//  - Trace: row t=WAVE_TOP+2*(255-s) (10-bit, no overflow for defaults). Pixel lit when
//    act_y within [min(t_prev,t),max(t_prev,t)] -> vertical fill, no gaps. t_prev = t of
//    column x-1; at column 0 t_prev=t. Trace colour FF/FF/00, overrides grid. Else black.
//  - act_x >= 2^ADDR_BITS never occurs (H_ACT <= 2048); no trace drawn if it does.
//  - Write side: wr_en && wr_ready writes back bank; wr_en while !wr_ready ignored.
//    wr_en + wr_done same cycle: write accepted, then pending=1. wr_done sets pending,
//    wr_ready=0 next cycle. wr_done while pending: ignored.
//  - Swap: on vs_in rising edge (vs_in & ~vs_d) with pending (or wr_done same cycle):
//    front bank toggles, pending=0, swap_ack=1 one cycle, wr_ready=1 next cycle.
//  - Reset mid-frame: output blank until next de_in rising edge; bank contents kept.
// CONFIGURATION
//  DSO_TRIG_MARK_EN defined: extra input trig_level[7:0]; row WAVE_TOP+2*(255-trig_level)
//   drawn as dashed cyan 00/FF/FF (lit when act_x[3]==0), priority trace > marker > grid.
//  Undefined: no trig_level port, no marker logic; rendering otherwise identical.
// TESTING
//  1 Reset held 4 cycles, de_in toggling -> all rgb/sync outs 0, wr_ready=1, swap_ack=0.
//  2 Write all bank samples=128, wr_done, one frame -> swap_ack 1 cycle after vs rise;
//    next frame row 538 lit yellow all columns, de_out = de_in delayed exactly 2 cycles.
//  3 Samples x0=255, x1=0 -> column 1 lit rows 284..794 contiguous (vertical fill).
//  4 Grid: empty trace (samples 0 -> row 794) -> px (192,5),(0,135),(1919,y) = 0x40 grey;
//    (193,136) black.
//  5 wr_done, then writes before vsync -> wr_ready=0, writes ignored; wr_done on vs rise
//    cycle -> swap same edge, swap_ack=1.
//  6 DSO_TRIG_MARK_EN, trig_level=0x80 -> row 538 cyan at x=0..7, black at x=8..15 (no trace).

Source files
------------

// File: rtl/dso_wave_render_if.sv
// Acquisition-side sample write and bank-swap handshake into the wave renderer.
interface dso_wave_render_if #(
   parameter int ADDR_BITS = 11
);
   logic                 wr_en;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [7:0]           wr_data;
   logic                 wr_done;
   logic                 wr_ready;
   logic                 swap_ack;

   modport master (output wr_en, wr_addr, wr_data, wr_done, input wr_ready, swap_ack);
   modport slave  (input wr_en, wr_addr, wr_data, wr_done, output wr_ready, swap_ack);
endinterface

// File: rtl/dso_wave_render.sv
// DSO pixel-stage renderer: graticule plus one 8-bit sample trace read from a vsync-swapped
// double-buffered line RAM. Build macro DSO_TRIG_MARK_EN adds a dashed trigger-level row.
module dso_wave_render #(
   parameter int X_BITS      = 12,
   parameter int Y_BITS      = 12,
   parameter int H_ACT       = 1920,
   parameter int V_ACT       = 1080,
   parameter int COLOR_DEPTH = 8,
   parameter int ADDR_BITS   = 11,
   parameter int GRID_X      = 192,
   parameter int GRID_Y      = 135,
   parameter int WAVE_TOP    = 284
) (
   input  logic                   pix_clk,
   input  logic                   rst,
   input  logic                   vs_in,
   input  logic                   hs_in,
   input  logic                   de_in,
   input  logic [X_BITS-1:0]      act_x,
   input  logic [Y_BITS-1:0]      act_y,
`ifdef DSO_TRIG_MARK_EN
   input  logic [7:0]             trig_level,
`endif
   dso_wave_render_if.slave       wr,
   output logic                   vs_out,
   output logic                   hs_out,
   output logic                   de_out,
   output logic [COLOR_DEPTH-1:0] r_out,
   output logic [COLOR_DEPTH-1:0] g_out,
   output logic [COLOR_DEPTH-1:0] b_out
);
   localparam int T_W   = Y_BITS + 1;
   localparam int GX_W  = (GRID_X > 1) ? $clog2(GRID_X) : 1;
   localparam int GY_W  = (GRID_Y > 1) ? $clog2(GRID_Y) : 1;
   localparam int PIX_W = 3 * COLOR_DEPTH;
   localparam logic [COLOR_DEPTH-1:0] C_FULL = '1;
   localparam logic [COLOR_DEPTH-1:0] C_GREY = COLOR_DEPTH'(1) << (COLOR_DEPTH - 2);
   localparam logic [COLOR_DEPTH-1:0] C_NONE = '0;

   function automatic logic [T_W-1:0] trace_row(input logic [7:0] s);
      return T_W'(WAVE_TOP) + T_W'({~s, 1'b0});
   endfunction

   function automatic logic [PIX_W-1:0] pick_colour(input logic trace, input logic mark,
                                                    input logic grid);
      if (trace) return {C_FULL, C_FULL, C_NONE};
      if (mark)  return {C_NONE, C_FULL, C_FULL};
      if (grid)  return {C_GREY, C_GREY, C_GREY};
      return '0;
   endfunction

   logic [7:0]      mem [0:(2**(ADDR_BITS+1))-1];
   logic            front, pending, wr_ready_q, swap_ack_q;
   logic            vs_d, de_d, blank;
   logic [GX_W-1:0] gx;
   logic [GY_W-1:0] gy;
   logic            vs_rise, de_rise, de_fall, done_req, do_swap, oob, mark_s0;
   logic [GX_W-1:0] gx_cur;

   assign vs_rise  = vs_in & ~vs_d;
   assign de_rise  = de_in & ~de_d;
   assign de_fall  = ~de_in & de_d;
   assign done_req = wr.wr_done & ~pending;
   assign do_swap  = vs_rise & (pending | done_req);
   assign gx_cur   = de_rise ? '0 : gx;
   assign oob      = 32'(act_x) >= (32'd1 << ADDR_BITS);

   assign wr.wr_ready = wr_ready_q;
   assign wr.swap_ack = swap_ack_q;

`ifdef DSO_TRIG_MARK_EN
   assign mark_s0 = ({1'b0, act_y} == trace_row(trig_level)) && !act_x[3];
`else
   assign mark_s0 = 1'b0;
`endif

   // bank control, grid counters; edge history is kept through reset so no false edges appear
   always_ff @(posedge pix_clk) begin
      vs_d <= vs_in;
      de_d <= de_in;
      if (rst) begin
         front      <= 1'b0;
         pending    <= 1'b0;
         wr_ready_q <= 1'b1;
         swap_ack_q <= 1'b0;
         gx         <= '0;
         gy         <= '0;
         blank      <= 1'b1;
      end else begin
         swap_ack_q <= do_swap;
         if (do_swap) begin
            front      <= ~front;
            pending    <= 1'b0;
            wr_ready_q <= 1'b1;
         end else if (done_req) begin
            pending    <= 1'b1;
            wr_ready_q <= 1'b0;
         end
         if (de_in)
            gx <= (gx_cur == GX_W'(GRID_X - 1)) ? '0 : gx_cur + 1'b1;
         if (vs_rise)
            gy <= '0;
         else if (de_fall)
            gy <= (gy == GY_W'(GRID_Y - 1)) ? '0 : gy + 1'b1;
         if (de_rise)
            blank <= 1'b0;
      end
   end

   // stage 1: line RAM read at act_x, grid and marker flags
   logic [7:0]        samp_p1;
   logic [Y_BITS-1:0] ay_p1;
   logic              grid_p1, x0_p1, oob_p1, mark_p1;
   logic              vs_p1, hs_p1, de_p1, vld_p1;

   always_ff @(posedge pix_clk) begin
      if (wr.wr_en && wr_ready_q)
         mem[{~front, wr.wr_addr}] <= wr.wr_data;
      samp_p1 <= mem[{front, act_x[ADDR_BITS-1:0]}];
      ay_p1   <= act_y;
      grid_p1 <= (gx_cur == '0) || (gy == '0) || (act_x == X_BITS'(H_ACT - 1)) ||
                 (act_y == Y_BITS'(V_ACT - 1));
      x0_p1   <= (act_x == '0);
      oob_p1  <= oob;
      mark_p1 <= mark_s0;
      if (rst) begin
         vs_p1  <= 1'b0;
         hs_p1  <= 1'b0;
         de_p1  <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vs_p1  <= vs_in;
         hs_p1  <= hs_in;
         de_p1  <= de_in;
         vld_p1 <= de_in && !(blank && !de_rise);
      end
   end

   // stage 2: trace span against the previous column, colour priority
   logic [T_W-1:0]   t_cur, t_prv, t_lo, t_hi, t_last;
   logic             hit;
   logic             vs_p2, hs_p2, de_p2;
   logic [PIX_W-1:0] rgb_p2;

   always_comb begin
      t_cur = trace_row(samp_p1);
      t_prv = x0_p1 ? t_cur : t_last;
      t_lo  = (t_prv < t_cur) ? t_prv : t_cur;
      t_hi  = (t_prv < t_cur) ? t_cur : t_prv;
      hit   = !oob_p1 && ({1'b0, ay_p1} >= t_lo) && ({1'b0, ay_p1} <= t_hi);
   end

   always_ff @(posedge pix_clk) begin
      if (de_p1)
         t_last <= t_cur;
      if (rst) begin
         vs_p2  <= 1'b0;
         hs_p2  <= 1'b0;
         de_p2  <= 1'b0;
         rgb_p2 <= '0;
      end else begin
         vs_p2  <= vs_p1;
         hs_p2  <= hs_p1;
         de_p2  <= de_p1;
         rgb_p2 <= vld_p1 ? pick_colour(hit, mark_p1, grid_p1) : '0;
      end
   end

   assign vs_out = vs_p2;
   assign hs_out = hs_p2;
   assign de_out = de_p2;
   assign {r_out, g_out, b_out} = rgb_p2;

endmodule

// File: tb/tb_dso_wave_render.sv
// Directed bench for dso_wave_render on a narrowed geometry (64-pixel lines, 16x4 grid cells).
`timescale 1ns/1ps
module tb_dso_wave_render;
   localparam int H_ACT     = 64;
   localparam int GRID_X    = 16;
   localparam int GRID_Y    = 4;
   localparam int ADDR_BITS = 11;
   localparam logic [23:0] YEL = 24'hFFFF00;
   localparam logic [23:0] GRY = 24'h404040;
   localparam logic [23:0] BLK = 24'h000000;
`ifdef DSO_TRIG_MARK_EN
   localparam logic [23:0] CYN = 24'h00FFFF;
   logic [7:0] trig_level = 8'h80;
`endif

   logic        pix_clk = 1'b0;
   logic        rst = 1'b1;
   logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
   logic [11:0] act_x = '0, act_y = '0;
   logic        vs_out, hs_out, de_out;
   logic [7:0]  r_out, g_out, b_out;

   dso_wave_render_if #(.ADDR_BITS(ADDR_BITS)) wr_if ();

   dso_wave_render #(
      .H_ACT(H_ACT), .GRID_X(GRID_X), .GRID_Y(GRID_Y), .ADDR_BITS(ADDR_BITS)
   ) dut (
      .pix_clk(pix_clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
      .act_x(act_x), .act_y(act_y),
`ifdef DSO_TRIG_MARK_EN
      .trig_level(trig_level),
`endif
      .wr(wr_if.slave), .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
      .r_out(r_out), .g_out(g_out), .b_out(b_out)
   );

   always #5 pix_clk = ~pix_clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Output capture: one row per rendered line, rows restart at each vs_out rise.
   logic [23:0] cap [0:7][0:63];
   int          cap_ln = 0, cap_x = 0;
   logic        vs_prev = 1'b0, de_prev = 1'b0;
   logic        vs_h1 = 1'b0, hs_h1 = 1'b0, de_h1 = 1'b0;
   logic        vs_h2 = 1'b0, hs_h2 = 1'b0, de_h2 = 1'b0;
   int          sync_err = 0;
   bit          chk_sync = 1'b0;

   always @(posedge pix_clk) begin
      {vs_h2, hs_h2, de_h2} <= {vs_h1, hs_h1, de_h1};
      {vs_h1, hs_h1, de_h1} <= {vs_in, hs_in, de_in};
   end

   always @(negedge pix_clk) begin
      vs_prev <= vs_out;
      de_prev <= de_out;
      if (vs_out && !vs_prev) begin
         cap_ln <= 0;
         cap_x  <= 0;
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 64; j++)
               cap[i][j] <= 24'h5A5A5A;
      end else if (de_out) begin
         cap[cap_ln[2:0]][cap_x[5:0]] <= {r_out, g_out, b_out};
         cap_x <= cap_x + 1;
      end else if (de_prev) begin
         cap_ln <= cap_ln + 1;
         cap_x  <= 0;
      end
      if (chk_sync && ({vs_out, hs_out, de_out} !== {vs_h2, hs_h2, de_h2}))
         sync_err <= sync_err + 1;
      if (!de_out && ({r_out, g_out, b_out} !== 24'h0))
         sync_err <= sync_err + 1;
   end

   typedef struct {
      int          ph;
      int          ln;
      int          x;
      logic [23:0] rgb;
   } vec_t;
   vec_t vt[$];

   function automatic void add(input int ph, input int ln, input int x, input logic [23:0] rgb);
      vec_t v;
      v.ph = ph; v.ln = ln; v.x = x; v.rgb = rgb;
      vt.push_back(v);
   endfunction

   task automatic check_phase(input int p);
      foreach (vt[i])
         if (vt[i].ph == p)
            chk($sformatf("px_ph%0d_ln%0d_x%0d", p, vt[i].ln, vt[i].x),
                {8'h0, cap[vt[i].ln][vt[i].x]}, {8'h0, vt[i].rgb});
   endtask

   logic [11:0] ys[$];

   task automatic line(input logic [11:0] y);
      for (int x = 0; x < H_ACT; x++) begin
         @(negedge pix_clk);
         de_in = 1'b1; act_x = 12'(x); act_y = y;
      end
      @(negedge pix_clk);
      de_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge pix_clk);
         hs_in = (i >= 2 && i < 4);
      end
   endtask

   task automatic run_lines();
      foreach (ys[i]) line(ys[i]);
   endtask

   task automatic wr1(input int a, input logic [7:0] d);
      @(negedge pix_clk);
      wr_if.wr_en = 1'b1; wr_if.wr_addr = ADDR_BITS'(a); wr_if.wr_data = d;
      @(negedge pix_clk);
      wr_if.wr_en = 1'b0;
   endtask

   task automatic write_bank(input logic [7:0] d);
      for (int a = 0; a < H_ACT; a++) begin
         @(negedge pix_clk);
         wr_if.wr_en = 1'b1; wr_if.wr_addr = ADDR_BITS'(a); wr_if.wr_data = d;
      end
      @(negedge pix_clk);
      wr_if.wr_en = 1'b0;
   endtask

   task automatic pulse_done();
      @(negedge pix_clk);
      wr_if.wr_done = 1'b1;
      @(negedge pix_clk);
      wr_if.wr_done = 1'b0;
   endtask

   // vs_in rises with optional same-cycle wr_done/write; returns swap_ack on the next two cycles
   task automatic vsync(input bit done_now, input bit we, input int wa, input logic [7:0] wd,
                        output bit ack_a, output bit ack_b);
      @(negedge pix_clk);
      vs_in = 1'b1; wr_if.wr_done = done_now;
      wr_if.wr_en = we; wr_if.wr_addr = ADDR_BITS'(wa); wr_if.wr_data = wd;
      @(negedge pix_clk);
      ack_a = wr_if.swap_ack;
      wr_if.wr_done = 1'b0; wr_if.wr_en = 1'b0;
      @(negedge pix_clk);
      ack_b = wr_if.swap_ack;
      vs_in = 1'b0;
      repeat (4) @(negedge pix_clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      bit a, b;
      wr_if.wr_en = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0; wr_if.wr_done = 1'b0;

      // phase 2: flat trace at row 538
      add(2, 0, 5, YEL);  add(2, 1, 0, YEL);  add(2, 1, 17, YEL); add(2, 1, 63, YEL);
      add(2, 2, 17, BLK); add(2, 2, 16, GRY); add(2, 2, 63, GRY);
      // phase 3: x0=255, x1=0 -> column 1 spans 284..794
      add(3, 1, 1, BLK);  add(3, 2, 1, YEL);  add(3, 2, 0, YEL);  add(3, 2, 2, BLK);
      add(3, 3, 1, YEL);  add(3, 3, 0, GRY);  add(3, 3, 2, BLK);  add(3, 4, 1, YEL);
      add(3, 4, 2, YEL);  add(3, 4, 5, YEL);  add(3, 4, 0, GRY);  add(3, 5, 1, BLK);
      // phase 4: grid with trace at row 794
      add(4, 0, 20, GRY); add(4, 1, 16, GRY); add(4, 1, 63, GRY); add(4, 1, 17, BLK);
      add(4, 2, 17, GRY); add(4, 3, 17, YEL); add(4, 3, 0, YEL);  add(4, 4, 5, GRY);
      add(4, 5, 17, BLK); add(4, 5, 16, GRY);
      // phase 5: writes while not ready were dropped
      add(5, 1, 0, YEL);  add(5, 1, 1, YEL);  add(5, 1, 5, BLK);  add(5, 1, 17, BLK);
      add(5, 2, 1, YEL);  add(5, 2, 3, BLK);
      // phase 6: same-edge wr_en + wr_done; column 10 = 128
      add(6, 1, 10, YEL); add(6, 1, 11, YEL); add(6, 1, 9, BLK);  add(6, 1, 12, BLK);
      add(6, 2, 9, YEL);  add(6, 2, 10, YEL); add(6, 2, 12, YEL);
      add(6, 3, 10, YEL); add(6, 3, 11, YEL); add(6, 3, 12, BLK); add(6, 3, 9, BLK);
      for (int x = 0; x < 8; x++)
`ifdef DSO_TRIG_MARK_EN
         add(6, 1, x, CYN);
`else
         add(6, 1, x, (x == 0) ? GRY : BLK);
`endif

      // reset held with de_in toggling
      for (int i = 0; i < 4; i++) begin
         @(negedge pix_clk);
         de_in = i[0]; act_x = 12'(i);
      end
      @(negedge pix_clk);
      chk("rst_rgb", {8'h0, r_out, g_out, b_out}, 32'h0);
      chk("rst_sync", {29'h0, vs_out, hs_out, de_out}, 32'h0);
      chk("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
      chk("rst_swap_ack", 32'(wr_if.swap_ack), 32'd0);
      rst = 1'b0; de_in = 1'b0; act_x = '0;
      repeat (3) @(negedge pix_clk);
      chk_sync = 1'b1;

      write_bank(8'd128);
      chk("ready_before_done", 32'(wr_if.wr_ready), 32'd1);
      pulse_done();
      chk("ready_after_done", 32'(wr_if.wr_ready), 32'd0);
      vsync(1'b0, 1'b0, 0, 8'd0, a, b);
      chk("p2_swap_ack", 32'(a), 32'd1);
      chk("p2_swap_ack_1cyc", 32'(b), 32'd0);
      chk("p2_ready_after_swap", 32'(wr_if.wr_ready), 32'd1);
      ys = '{12'd538, 12'd538, 12'd537};
      run_lines();
      check_phase(2);

      write_bank(8'd0);
      wr1(0, 8'd255);
      wr1(1, 8'd0);
      pulse_done();
      vsync(1'b0, 1'b0, 0, 8'd0, a, b);
      chk("p3_swap_ack", 32'(a), 32'd1);
      ys = '{12'd100, 12'd283, 12'd284, 12'd500, 12'd794, 12'd795};
      run_lines();
      check_phase(3);

      write_bank(8'd0);
      pulse_done();
      vsync(1'b0, 1'b0, 0, 8'd0, a, b);
      chk("p4_swap_ack", 32'(a), 32'd1);
      ys = '{12'd0, 12'd1, 12'd1079, 12'd794, 12'd4, 12'd5};
      run_lines();
      check_phase(4);

      pulse_done();
      chk("p5_ready_pending", 32'(wr_if.wr_ready), 32'd0);
      write_bank(8'd255);
      chk("p5_ready_still_low", 32'(wr_if.wr_ready), 32'd0);
      pulse_done();
      chk("p5_ready_dup_done", 32'(wr_if.wr_ready), 32'd0);
      vsync(1'b0, 1'b0, 0, 8'd0, a, b);
      chk("p5_swap_ack", 32'(a), 32'd1);
      chk("p5_swap_ack_1cyc", 32'(b), 32'd0);
      chk("p5_ready_after_swap", 32'(wr_if.wr_ready), 32'd1);
      ys = '{12'd100, 12'd284, 12'd500};
      run_lines();
      check_phase(5);

      vsync(1'b1, 1'b1, 10, 8'd128, a, b);
      chk("p6_same_edge_ack", 32'(a), 32'd1);
      chk("p6_same_edge_ack_1cyc", 32'(b), 32'd0);
      chk("p6_ready_no_pending", 32'(wr_if.wr_ready), 32'd1);
      ys = '{12'd100, 12'd538, 12'd794, 12'd600};
      run_lines();
      check_phase(6);

      repeat (4) @(negedge pix_clk);
      chk("sync_delay_and_blank", 32'(sync_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
